// File: rtl/chu_uart_ex_defs.sv
// Shared definitions for the chu_uart_ex MMIO UART: register map, status and
// control bit positions, FSM encodings and oversampling constants.
package chu_uart_ex_defs;

    localparam logic [2:0] REG_STATUS  = 3'd0;
    localparam logic [2:0] REG_DVSR    = 3'd1;
    localparam logic [2:0] REG_TX_DATA = 3'd2;
    localparam logic [2:0] REG_RX_POP  = 3'd3;
    localparam logic [2:0] REG_CTRL    = 3'd4;
    localparam logic [2:0] REG_ERR_CLR = 3'd5;

    localparam int ST_RX_EMPTY   = 8;
    localparam int ST_TX_FULL    = 9;
    localparam int ST_PARITY_ERR = 10;
    localparam int ST_FRAME_ERR  = 11;
    localparam int ST_OVERRUN    = 12;
    localparam int ST_TX_IDLE    = 13;

    localparam int CTRL_PARITY_EN  = 0;
    localparam int CTRL_PARITY_ODD = 1;
    localparam int CTRL_TWO_STOP   = 2;
    localparam int CTRL_RX_IRQ_EN  = 3;
    localparam int CTRL_TX_IRQ_EN  = 4;
    localparam int CTRL_LOOPBACK   = 5;

    localparam int OVERSAMPLE  = 16;
    localparam int GLITCH_TICK = 7;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO with 2^AW entries; push and pop
// together always succeed and leave occupancy unchanged, even when full or empty.
module uart_fifo #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wr_data,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] head
);

    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg, count_next;
    logic          do_push, do_pop;

    assign full    = count_reg[AW];
    assign empty   = (count_reg == '0);
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & (~empty | push);
    assign head    = mem[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        if (do_push && !do_pop)
            count_next = count_reg + 1'b1;
        else if (do_pop && !do_push)
            count_next = count_reg - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/chu_uart_ex.sv
// MMIO UART slot core: baud generator, TX/RX FSMs, sticky errors and irq.
// Define UART_LOOPBACK_EN to implement the internal loopback control bit.
module chu_uart_ex
    import chu_uart_ex_defs::*;
#(
    parameter int DBIT   = 8,
    parameter int FIFO_W = 8,
    parameter int DVSR_W = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        tx,
    input  logic        rx,
    output logic        irq
);

    logic [DVSR_W-1:0] dvsr_reg, dvsr_next, baud_cnt_reg, baud_cnt_next;
    logic [5:0]        ctrl_reg, ctrl_next;
    logic [2:0]        err_reg, err_next, err_set, err_clr;
    logic              irq_reg, irq_next, tick, wr_en, tx_idle;
    logic              rx_meta_reg, rx_sync_reg, rx_src;

    tx_state_t         tx_state_reg, tx_state_next;
    logic [4:0]        tx_s_reg, tx_s_next;
    logic [2:0]        tx_n_reg, tx_n_next;
    logic [DBIT-1:0]   tx_b_reg, tx_b_next;
    logic              tx_par_reg, tx_par_next, tx_bit_reg, tx_bit_next;

    rx_state_t         rx_state_reg, rx_state_next;
    logic [3:0]        rx_s_reg, rx_s_next;
    logic [2:0]        rx_n_reg, rx_n_next;
    logic [DBIT-1:0]   rx_b_reg, rx_b_next;

    logic              tx_fifo_push, tx_fifo_pop, tx_full, tx_empty;
    logic              rx_fifo_push, rx_fifo_pop, rx_full, rx_empty;
    logic [DBIT-1:0]   tx_head, rx_head;
    logic [7:0]        rx_byte;
    logic              unused_bits;

    assign unused_bits  = ^{read, addr[4:3], wr_data};
    assign wr_en        = cs & write;
    assign tx_fifo_push = wr_en && (addr[2:0] == REG_TX_DATA);
    assign rx_fifo_pop  = wr_en && (addr[2:0] == REG_RX_POP) && !rx_empty;
    assign err_clr      = (wr_en && (addr[2:0] == REG_ERR_CLR)) ? wr_data[12:10] : 3'b000;
    assign tick         = (baud_cnt_reg == dvsr_reg);
    assign tx_idle      = (tx_state_reg == TX_IDLE) && tx_empty;
    assign irq          = irq_reg;

`ifdef UART_LOOPBACK_EN
    assign rx_src = ctrl_reg[CTRL_LOOPBACK] ? tx_bit_reg : rx;
    assign tx     = tx_bit_reg | ctrl_reg[CTRL_LOOPBACK];
`else
    assign rx_src = rx;
    assign tx     = tx_bit_reg;
`endif

    uart_fifo #(.DW(DBIT), .AW(FIFO_W)) tx_fifo (
        .clk(clk), .reset(reset), .push(tx_fifo_push), .pop(tx_fifo_pop),
        .wr_data(wr_data[DBIT-1:0]), .full(tx_full), .empty(tx_empty), .head(tx_head)
    );

    uart_fifo #(.DW(DBIT), .AW(FIFO_W)) rx_fifo (
        .clk(clk), .reset(reset), .push(rx_fifo_push), .pop(rx_fifo_pop),
        .wr_data(rx_b_reg), .full(rx_full), .empty(rx_empty), .head(rx_head)
    );

    always_comb begin
        dvsr_next     = dvsr_reg;
        ctrl_next     = ctrl_reg;
        baud_cnt_next = tick ? '0 : baud_cnt_reg + 1'b1;
        if (wr_en && (addr[2:0] == REG_DVSR))
            dvsr_next = wr_data[DVSR_W-1:0];
        if (wr_en && (addr[2:0] == REG_CTRL)) begin
            ctrl_next = wr_data[5:0];
`ifndef UART_LOOPBACK_EN
            ctrl_next[CTRL_LOOPBACK] = 1'b0;
`endif
        end
        // Hardware set is OR-ed in after the clear so it wins a same-cycle collision.
        err_next = (err_reg & ~err_clr) | err_set;
        irq_next = (ctrl_reg[CTRL_RX_IRQ_EN] & ~rx_empty) |
                   (ctrl_reg[CTRL_TX_IRQ_EN] & tx_idle) |
                   (ctrl_reg[CTRL_RX_IRQ_EN] & (|err_reg));
    end

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_s_next     = tx_s_reg;
        tx_n_next     = tx_n_reg;
        tx_b_next     = tx_b_reg;
        tx_par_next   = tx_par_reg;
        tx_bit_next   = 1'b1;
        tx_fifo_pop   = 1'b0;
        case (tx_state_reg)
            TX_IDLE: begin
                if (tick && !tx_empty) begin
                    tx_fifo_pop   = 1'b1;
                    tx_b_next     = tx_head;
                    tx_par_next   = (^tx_head) ^ ctrl_reg[CTRL_PARITY_ODD];
                    tx_s_next     = '0;
                    tx_state_next = TX_START;
                end
            end
            TX_START: begin
                tx_bit_next = 1'b0;
                if (tick) begin
                    if (tx_s_reg == 5'(OVERSAMPLE-1)) begin
                        tx_s_next     = '0;
                        tx_n_next     = '0;
                        tx_state_next = TX_DATA;
                    end else
                        tx_s_next = tx_s_reg + 1'b1;
                end
            end
            TX_DATA: begin
                tx_bit_next = tx_b_reg[0];
                if (tick) begin
                    if (tx_s_reg == 5'(OVERSAMPLE-1)) begin
                        tx_s_next = '0;
                        tx_b_next = tx_b_reg >> 1;
                        if (tx_n_reg == 3'(DBIT-1))
                            tx_state_next = ctrl_reg[CTRL_PARITY_EN] ? TX_PARITY : TX_STOP;
                        else
                            tx_n_next = tx_n_reg + 1'b1;
                    end else
                        tx_s_next = tx_s_reg + 1'b1;
                end
            end
            TX_PARITY: begin
                tx_bit_next = tx_par_reg;
                if (tick) begin
                    if (tx_s_reg == 5'(OVERSAMPLE-1)) begin
                        tx_s_next     = '0;
                        tx_state_next = TX_STOP;
                    end else
                        tx_s_next = tx_s_reg + 1'b1;
                end
            end
            TX_STOP: begin
                if (tick) begin
                    if (tx_s_reg == (ctrl_reg[CTRL_TWO_STOP] ? 5'(2*OVERSAMPLE-1) : 5'(OVERSAMPLE-1)))
                        tx_state_next = TX_IDLE;
                    else
                        tx_s_next = tx_s_reg + 1'b1;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_s_next     = rx_s_reg;
        rx_n_next     = rx_n_reg;
        rx_b_next     = rx_b_reg;
        rx_fifo_push  = 1'b0;
        err_set       = 3'b000;
        case (rx_state_reg)
            RX_IDLE: begin
                if (!rx_sync_reg) begin
                    rx_s_next     = '0;
                    rx_state_next = RX_START;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (rx_s_reg == 4'(GLITCH_TICK)) begin
                        rx_s_next     = '0;
                        rx_n_next     = '0;
                        rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
                    end else
                        rx_s_next = rx_s_reg + 1'b1;
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (rx_s_reg == 4'(OVERSAMPLE-1)) begin
                        rx_s_next = '0;
                        rx_b_next = {rx_sync_reg, rx_b_reg[DBIT-1:1]};
                        if (rx_n_reg == 3'(DBIT-1))
                            rx_state_next = ctrl_reg[CTRL_PARITY_EN] ? RX_PARITY : RX_STOP;
                        else
                            rx_n_next = rx_n_reg + 1'b1;
                    end else
                        rx_s_next = rx_s_reg + 1'b1;
                end
            end
            RX_PARITY: begin
                if (tick) begin
                    if (rx_s_reg == 4'(OVERSAMPLE-1)) begin
                        rx_s_next     = '0;
                        err_set[0]    = rx_sync_reg ^ (^rx_b_reg) ^ ctrl_reg[CTRL_PARITY_ODD];
                        rx_state_next = RX_STOP;
                    end else
                        rx_s_next = rx_s_reg + 1'b1;
                end
            end
            RX_STOP: begin
                if (tick) begin
                    if (rx_s_reg == 4'(OVERSAMPLE-1)) begin
                        err_set[1]    = ~rx_sync_reg;
                        err_set[2]    = rx_full & ~rx_fifo_pop;
                        rx_fifo_push  = 1'b1;
                        rx_state_next = RX_IDLE;
                    end else
                        rx_s_next = rx_s_reg + 1'b1;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rd_data = '0;
        rx_byte = '0;
        if (!rx_empty)
            rx_byte[DBIT-1:0] = rx_head;
        case (addr[2:0])
            REG_STATUS: begin
                rd_data[7:0]                      = rx_byte;
                rd_data[ST_RX_EMPTY]              = rx_empty;
                rd_data[ST_TX_FULL]               = tx_full;
                rd_data[ST_OVERRUN:ST_PARITY_ERR] = err_reg;
                rd_data[ST_TX_IDLE]               = tx_idle;
            end
            REG_DVSR: rd_data[DVSR_W-1:0] = dvsr_reg;
            REG_CTRL: rd_data[5:0]        = ctrl_reg;
            default:  rd_data             = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dvsr_reg     <= '0;
            ctrl_reg     <= '0;
            baud_cnt_reg <= '0;
            err_reg      <= '0;
            irq_reg      <= 1'b0;
            rx_meta_reg  <= 1'b1;
            rx_sync_reg  <= 1'b1;
            tx_state_reg <= TX_IDLE;
            tx_s_reg     <= '0;
            tx_n_reg     <= '0;
            tx_b_reg     <= '0;
            tx_par_reg   <= 1'b0;
            tx_bit_reg   <= 1'b1;
            rx_state_reg <= RX_IDLE;
            rx_s_reg     <= '0;
            rx_n_reg     <= '0;
            rx_b_reg     <= '0;
        end else begin
            dvsr_reg     <= dvsr_next;
            ctrl_reg     <= ctrl_next;
            baud_cnt_reg <= baud_cnt_next;
            err_reg      <= err_next;
            irq_reg      <= irq_next;
            rx_meta_reg  <= rx_src;
            rx_sync_reg  <= rx_meta_reg;
            tx_state_reg <= tx_state_next;
            tx_s_reg     <= tx_s_next;
            tx_n_reg     <= tx_n_next;
            tx_b_reg     <= tx_b_next;
            tx_par_reg   <= tx_par_next;
            tx_bit_reg   <= tx_bit_next;
            rx_state_reg <= rx_state_next;
            rx_s_reg     <= rx_s_next;
            rx_n_reg     <= rx_n_next;
            rx_b_reg     <= rx_b_next;
        end
    end

endmodule

// File: tb/tb_chu_uart_ex.sv
// Directed bench for chu_uart_ex with a 4-entry FIFO; dvsr=3 gives 64 clks per bit.
module tb_chu_uart_ex;

    localparam int BIT_CLKS = 64;

    logic        clk = 1'b0;
    logic        reset, cs, read, write, rx;
    logic [4:0]  addr;
    logic [31:0] wr_data, rd_data;
    logic        tx, irq;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    chu_uart_ex #(.DBIT(8), .FIFO_W(2), .DVSR_W(11)) dut (
        .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .tx(tx), .rx(rx), .irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end else
            $display("ok   %s: 0x%08h", tag, got);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        addr = {2'b00, a}; wr_data = d; cs = 1'b1; write = 1'b1;
        wait_clks(1);
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] v;
        addr = {2'b00, a}; cs = 1'b1; read = 1'b1;
        #1;
        v = rd_data;
        cs = 1'b0; read = 1'b0;
        check(tag, v, exp);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_en, input bit par_bit, input bit stop_bit);
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clks(BIT_CLKS);
        end
        if (par_en) begin
            rx = par_bit;
            wait_clks(BIT_CLKS);
        end
        rx = stop_bit;
        wait_clks(BIT_CLKS);
        rx = 1'b1;
    endtask

    task automatic wait_tx_fall(input string tag);
        int cnt = 0;
        while (tx !== 1'b0 && cnt < 300) begin
            wait_clks(1);
            cnt++;
        end
        check(tag, (cnt < 300) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        int low, lows;
        reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0;
        addr = '0; wr_data = '0; rx = 1'b1;
        wait_clks(3);
        reset = 1'b0;
        wait_clks(1);

        read_check("reset_status", 3'd0, 32'h0000_2100);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_irq", 32'(irq), 32'd0);

        // TX of 0x55 with even parity
        bus_write(3'd1, 32'd3);
        read_check("dvsr_readback", 3'd1, 32'd3);
        bus_write(3'd4, 32'h01);
        bus_write(3'd2, 32'h55);
        wait_tx_fall("tx_start_seen");
        low = 0;
        while (tx === 1'b0 && low < 200) begin
            wait_clks(1);
            low++;
        end
        check("tx_start_len", 32'(low), 32'd64);
        pat = 8'h55;
        wait_clks(BIT_CLKS / 2);
        check("tx_bit0", 32'(tx), 32'(pat[0]));
        read_check("tx_busy_status", 3'd0, 32'h0000_0100);
        for (int i = 1; i < 8; i++) begin
            wait_clks(BIT_CLKS);
            check($sformatf("tx_bit%0d", i), 32'(tx), 32'(pat[i]));
        end
        wait_clks(BIT_CLKS);
        check("tx_parity", 32'(tx), 32'd0);
        wait_clks(BIT_CLKS);
        check("tx_stop", 32'(tx), 32'd1);
        wait_clks(BIT_CLKS);
        read_check("tx_idle_back", 3'd0, 32'h0000_2100);

        // RX 0xA3 with a wrong (odd) parity bit under even parity
        bus_write(3'd4, 32'h09);
        send_frame(8'hA3, 1'b1, 1'b1, 1'b1);
        wait_clks(2);
        read_check("rx_parity_err", 3'd0, 32'h0000_24A3);
        check("irq_rx", 32'(irq), 32'd1);
        bus_write(3'd5, 32'h400);
        bus_write(3'd3, 32'h0);
        wait_clks(2);
        check("irq_cleared", 32'(irq), 32'd0);
        read_check("rx_cleared", 3'd0, 32'h0000_2100);

        // Overrun a 4-deep RX FIFO
        bus_write(3'd4, 32'h00);
        for (int k = 1; k <= 5; k++)
            send_frame(8'(k), 1'b0, 1'b0, 1'b1);
        wait_clks(2);
        for (int k = 1; k <= 4; k++) begin
            read_check($sformatf("ovr_head%0d", k), 3'd0, 32'h0000_3000 | 32'(k));
            bus_write(3'd3, 32'h0);
        end
        read_check("ovr_drained", 3'd0, 32'h0000_3100);
        bus_write(3'd5, 32'h1000);
        read_check("ovr_cleared", 3'd0, 32'h0000_2100);

        // Short low glitch, then a frame with a bad stop bit
        rx = 1'b0;
        wait_clks(16);
        rx = 1'b1;
        wait_clks(700);
        read_check("glitch_reject", 3'd0, 32'h0000_2100);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        wait_clks(4);
        read_check("frame_err", 3'd0, 32'h0000_285A);
        read_check("unused_offset", 3'd6, 32'h0);

        // Reset in the middle of a start bit with a second word queued
        bus_write(3'd2, 32'h3C);
        bus_write(3'd2, 32'h81);
        wait_tx_fall("tx2_start_seen");
        wait_clks(10);
        check("tx_low_pre_reset", 32'(tx), 32'd0);
        reset = 1'b1;
        #1;
        check("tx_high_in_reset", 32'(tx), 32'd1);
        wait_clks(2);
        reset = 1'b0;
        wait_clks(1);
        read_check("post_reset_status", 3'd0, 32'h0000_2100);
        lows = 0;
        repeat (100) begin
            wait_clks(1);
            if (tx !== 1'b1) lows++;
        end
        check("tx_quiet_after_reset", 32'(lows), 32'd0);

`ifdef UART_LOOPBACK_EN
        bus_write(3'd1, 32'd3);
        bus_write(3'd4, 32'h20);
        read_check("ctrl_loopback", 3'd4, 32'h20);
        bus_write(3'd2, 32'h3C);
        lows = 0;
        repeat (800) begin
            wait_clks(1);
            if (tx !== 1'b1) lows++;
        end
        check("tx_held_high", 32'(lows), 32'd0);
        read_check("loopback_head", 3'd0, 32'h0000_203C);
`else
        bus_write(3'd4, 32'h3F);
        read_check("ctrl_no_loopback", 3'd4, 32'h1F);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
